// File: rtl/cmp_swap_stage.sv
// -----------------------------------------------------------------------------
// cmp_swap_stage
//
// Compare-and-swap datapath stage for the bubble-sort controller. It sits
// directly after the inner-loop j generator. For each start pulse carrying
// index j, the stage:
//   1. reads mem[j] and mem[j+1] from a single-port synchronous RAM,
//   2. compares the two words (unsigned),
//   3. writes them back exchanged if they are out of order,
//   4. pulses o_done, which feeds the j generator's enable.
//
// Build option:
//   CMP_SWAP_DESCEND_EN  defined   -> swap when a < b (descending sort)
//                        undefined -> swap when a > b (ascending sort)
//   Timing and interface are the same in both builds.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   i_start      one-cycle start pulse; i_value_j is valid in the same cycle
//   i_value_j    index j; the stage processes the pair (j, j+1)
//   i_clr_cnt    synchronous clear of o_swap_cnt (wins over an increment)
//   o_mem_addr   RAM address (0 when neither enable is active)
//   o_mem_re     RAM read enable
//   o_mem_we     RAM write enable (never high together with o_mem_re)
//   o_mem_wdata  RAM write data (0 when o_mem_we is low)
//   i_mem_rdata  RAM read data, valid one cycle after o_mem_re
//   o_busy       high in every state except IDLE
//   o_done       one-cycle pulse when the pair has been processed
//   o_swapped    valid with o_done: 1 if the pair was exchanged
//   o_swap_cnt   saturating count of swaps performed
// -----------------------------------------------------------------------------
module cmp_swap_stage #(
  parameter int SIZE_ADDR = 8,
  parameter int DATA_W    = 16,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_start,
  input  logic [SIZE_ADDR-1:0] i_value_j,
  input  logic                 i_clr_cnt,
  output logic [SIZE_ADDR-1:0] o_mem_addr,
  output logic                 o_mem_re,
  output logic                 o_mem_we,
  output logic [DATA_W-1:0]    o_mem_wdata,
  input  logic [DATA_W-1:0]    i_mem_rdata,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_swapped,
  output logic [CNT_W-1:0]     o_swap_cnt
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD0  = 3'd1,
    RD1  = 3'd2,
    CMP  = 3'd3,
    WR0  = 3'd4,
    WR1  = 3'd5,
    DONE = 3'd6
  } state_t;

  state_t               state, state_nx;
  logic [SIZE_ADDR-1:0] j_r;
  logic [SIZE_ADDR-1:0] j_p1;
  logic [DATA_W-1:0]    a_r, b_r;
  logic                 swap_r;
  logic                 swap_c;

  // Address of the second element; wraps modulo 2^SIZE_ADDR. Range keeping
  // is the upstream generator's job.
  assign j_p1 = j_r + {{(SIZE_ADDR-1){1'b0}}, 1'b1};

  // The compare uses the registered first word against the second word
  // straight off the RAM bus during CMP, saving a cycle.
`ifdef CMP_SWAP_DESCEND_EN
  assign swap_c = (a_r < i_mem_rdata);
`else
  assign swap_c = (a_r > i_mem_rdata);
`endif

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // ---------------------------------------------------------------------------
  // Next state and outputs. All outputs decode from the state alone, so an
  // asynchronous reset drops every enable in the same instant and a pending
  // write can never reach the RAM.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nx    = state;
    o_mem_addr  = '0;
    o_mem_re    = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_wdata = '0;
    o_busy      = 1'b1;
    o_done      = 1'b0;
    o_swapped   = 1'b0;
    case (state)
      IDLE: begin
        o_busy = 1'b0;
        if (i_start) state_nx = RD0;
      end
      RD0: begin
        o_mem_addr = j_r;
        o_mem_re   = 1'b1;
        state_nx   = RD1;
      end
      RD1: begin
        o_mem_addr = j_p1;
        o_mem_re   = 1'b1;
        state_nx   = CMP;
      end
      CMP: begin
        state_nx = swap_c ? WR0 : DONE;
      end
      WR0: begin
        o_mem_addr  = j_r;
        o_mem_we    = 1'b1;
        o_mem_wdata = b_r;
        state_nx    = WR1;
      end
      WR1: begin
        o_mem_addr  = j_p1;
        o_mem_we    = 1'b1;
        o_mem_wdata = a_r;
        state_nx    = DONE;
      end
      DONE: begin
        o_done    = 1'b1;
        o_swapped = swap_r;
        state_nx  = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers: index, both operands and the swap decision.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      j_r    <= '0;
      a_r    <= '0;
      b_r    <= '0;
      swap_r <= 1'b0;
    end else begin
      case (state)
        IDLE: if (i_start) j_r <= i_value_j;
        // RAM returns mem[j] in the cycle after RD0, i.e. during RD1.
        RD1:  a_r <= i_mem_rdata;
        // mem[j+1] arrives during CMP.
        CMP: begin
          b_r    <= i_mem_rdata;
          swap_r <= swap_c;
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Swap counter: clear wins, then saturating increment while in DONE.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_swap_cnt <= '0;
    end else if (i_clr_cnt) begin
      o_swap_cnt <= '0;
    end else if (state == DONE && swap_r && o_swap_cnt != {CNT_W{1'b1}}) begin
      o_swap_cnt <= o_swap_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_cmp_swap_stage.sv
// -----------------------------------------------------------------------------
// tb_cmp_swap_stage
//
// Scoreboard bench for cmp_swap_stage. A reference copy of RAM contents
// predicts each pair's reads, writes, swap flag and latency; predictions are
// queued when a start is driven and consumed by a negedge monitor as the DUT
// produces them. Also drives a small bubble-sort loop standing in for the
// i/j generators.
// -----------------------------------------------------------------------------
module tb_cmp_swap_stage;

  localparam int SIZE_ADDR = 8;
  localparam int DATA_W    = 16;
  localparam int CNT_W     = 16;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 i_start;
  logic [SIZE_ADDR-1:0] i_value_j;
  logic                 i_clr_cnt;
  logic [SIZE_ADDR-1:0] o_mem_addr;
  logic                 o_mem_re;
  logic                 o_mem_we;
  logic [DATA_W-1:0]    o_mem_wdata;
  logic [DATA_W-1:0]    i_mem_rdata;
  logic                 o_busy;
  logic                 o_done;
  logic                 o_swapped;
  logic [CNT_W-1:0]     o_swap_cnt;

  cmp_swap_stage #(.SIZE_ADDR(SIZE_ADDR), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_start     (i_start),
    .i_value_j   (i_value_j),
    .i_clr_cnt   (i_clr_cnt),
    .o_mem_addr  (o_mem_addr),
    .o_mem_re    (o_mem_re),
    .o_mem_we    (o_mem_we),
    .o_mem_wdata (o_mem_wdata),
    .i_mem_rdata (i_mem_rdata),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_swapped   (o_swapped),
    .o_swap_cnt  (o_swap_cnt)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Synchronous single-port RAM with a bench load port.
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0]    ram [256];
  logic                 ld_en = 1'b0;
  logic [SIZE_ADDR-1:0] ld_addr = '0;
  logic [DATA_W-1:0]    ld_data = '0;

  always @(posedge clk) begin
    if (ld_en)         ram[ld_addr] <= ld_data;
    else if (o_mem_we) ram[o_mem_addr] <= o_mem_wdata;
    if (o_mem_re) i_mem_rdata <= ram[o_mem_addr];
  end

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [SIZE_ADDR-1:0] addr;
    logic [DATA_W-1:0]    data;
  } wr_t;

  logic [DATA_W-1:0]    ref_mem [256];
  logic [SIZE_ADDR-1:0] rd_q [$];
  wr_t                  wr_q [$];
  logic                 done_q [$];
  logic [CNT_W-1:0]     exp_cnt = '0;
  int                   cyc = 0;
  int                   start_cyc = 0;
  int                   n_chk = 0;
  int                   n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Monitor: sample away from the active edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      wr_t  w;
      logic e;
      if (o_busy) chk("re_we_excl", {31'd0, o_mem_re & o_mem_we}, 32'd0);
      if (!o_done) chk("swapped_idle", {31'd0, o_swapped}, 32'd0);
      if (o_mem_re) begin
        if (rd_q.size() == 0) chk("rd_unexp", {31'd0, o_mem_re}, 32'd0);
        else chk("rd_addr", 32'(o_mem_addr), 32'(rd_q.pop_front()));
      end
      if (o_mem_we) begin
        if (wr_q.size() == 0) chk("wr_unexp", {31'd0, o_mem_we}, 32'd0);
        else begin
          w = wr_q.pop_front();
          chk("wr_addr", 32'(o_mem_addr), 32'(w.addr));
          chk("wr_data", 32'(o_mem_wdata), 32'(w.data));
        end
      end
      e = 1'b0;
      if (o_done) begin
        if (done_q.size() == 0) chk("done_unexp", {31'd0, o_done}, 32'd0);
        else begin
          e = done_q.pop_front();
          chk("swapped", {31'd0, o_swapped}, {31'd0, e});
          chk("latency", 32'(cyc - start_cyc), e ? 32'd5 : 32'd3);
        end
      end
      // Model the counter update at the coming edge.
      if (i_clr_cnt) exp_cnt = '0;
      else if (o_done && e && exp_cnt != {CNT_W{1'b1}}) exp_cnt = exp_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (all drive at posedge + 1)
  // ---------------------------------------------------------------------------
  task automatic load(input int addr, input int data);
    ld_en   = 1'b1;
    ld_addr = SIZE_ADDR'(addr);
    ld_data = DATA_W'(data);
    ref_mem[SIZE_ADDR'(addr)] = DATA_W'(data);
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (o_busy && k < 30) begin
      @(posedge clk); #1;
      k++;
    end
    chk("idle_timeout", {31'd0, o_busy}, 32'd0);
    chk("pending", 32'(done_q.size() + wr_q.size() + rd_q.size()), 32'd0);
    chk("swap_cnt", 32'(o_swap_cnt), 32'(exp_cnt));
  endtask

  task automatic start_pair(input int j, input bit extra);
    logic [SIZE_ADDR-1:0] j0, j1;
    logic [DATA_W-1:0]    a, b;
    logic                 sw;
    j0 = SIZE_ADDR'(j);
    j1 = j0 + 1'b1;
    a  = ref_mem[j0];
    b  = ref_mem[j1];
`ifdef CMP_SWAP_DESCEND_EN
    sw = (a < b);
`else
    sw = (a > b);
`endif
    rd_q.push_back(j0);
    rd_q.push_back(j1);
    if (sw) begin
      wr_q.push_back('{addr: j0, data: b});
      wr_q.push_back('{addr: j1, data: a});
      ref_mem[j0] = b;
      ref_mem[j1] = a;
    end
    done_q.push_back(sw);
    i_start   = 1'b1;
    i_value_j = j0;
    @(posedge clk); #1;
    start_cyc = cyc;
    i_start   = 1'b0;
    i_value_j = '0;
    if (extra) begin
      @(posedge clk); #1;          // now in RD1
      i_start   = 1'b1;
      i_value_j = j0 + 8'd5;
      @(posedge clk); #1;
      i_start   = 1'b0;
      i_value_j = '0;
    end
    wait_idle();
  endtask

  task automatic chk_ram(input string tag, input int addr);
    chk(tag, 32'(ram[SIZE_ADDR'(addr)]), 32'(ref_mem[SIZE_ADDR'(addr)]));
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  int swp_a, swp_b;   // a pair that swaps in the current build

  initial begin
`ifdef CMP_SWAP_DESCEND_EN
    swp_a = 20; swp_b = 200;
`else
    swp_a = 200; swp_b = 20;
`endif
    rst_n     = 1'b0;
    i_start   = 1'b0;
    i_value_j = '0;
    i_clr_cnt = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy",  {31'd0, o_busy}, 32'd0);
    chk("rst_done",  {31'd0, o_done}, 32'd0);
    chk("rst_re_we", {30'd0, o_mem_re, o_mem_we}, 32'd0);
    chk("rst_addr",  32'(o_mem_addr), 32'd0);
    chk("rst_wdata", 32'(o_mem_wdata), 32'd0);
    chk("rst_swp",   {31'd0, o_swapped}, 32'd0);
    chk("rst_cnt",   32'(o_swap_cnt), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Out-of-order pair (ascending build swaps).
    load(3, 9); load(4, 2);
    start_pair(3, 1'b0);
    chk_ram("ram3", 3); chk_ram("ram4", 4);

    // In-order pair.
    load(0, 1); load(1, 7);
    start_pair(0, 1'b0);
    chk_ram("ram0", 0); chk_ram("ram1", 1);

    // Equal values never swap.
    load(5, 4); load(6, 4);
    start_pair(5, 1'b0);

    // Second start during RD1 is ignored, then a fresh start is accepted.
    load(7, swp_a); load(8, swp_b);
    start_pair(7, 1'b1);
    chk_ram("ram7", 7); chk_ram("ram8", 8);
    start_pair(7, 1'b0);
    chk_ram("ram7b", 7);

    // j = 255 wraps the second address to 0.
    load(255, 65535); load(0, 0);
    start_pair(255, 1'b0);
    chk_ram("ram255", 255); chk_ram("ram0w", 0);

    // Clear held through a swapping pair: clear wins over the increment.
    load(20, swp_a); load(21, swp_b);
    i_clr_cnt = 1'b1;
    start_pair(20, 1'b0);
    i_clr_cnt = 1'b0;
    chk("clr_cnt", 32'(o_swap_cnt), 32'd0);

    // Reset during WR0 aborts with no write and no done.
    load(10, swp_a); load(11, swp_b);
    rd_q.push_back(8'd10);
    rd_q.push_back(8'd11);
    i_start = 1'b1; i_value_j = 8'd10;
    @(posedge clk); #1;
    i_start = 1'b0; i_value_j = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("wr0_we", {31'd0, o_mem_we}, 32'd1);
    rst_n   = 1'b0;
    exp_cnt = '0;
    #1;
    chk("abort_we",   {31'd0, o_mem_we}, 32'd0);
    chk("abort_busy", {31'd0, o_busy}, 32'd0);
    chk("abort_done", {31'd0, o_done}, 32'd0);
    chk("abort_addr", 32'(o_mem_addr), 32'd0);
    chk("abort_wd",   32'(o_mem_wdata), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_ram10", 32'(ram[10]), 32'(swp_a));
    chk("abort_ram11", 32'(ram[11]), 32'(swp_b));
    wait_idle();

    // Full bubble sort of five elements.
    for (int k = 0; k < 5; k++) begin
`ifdef CMP_SWAP_DESCEND_EN
      load(k, k + 1);
`else
      load(k, 5 - k);
`endif
    end
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4 - i; j++)
        start_pair(j, 1'b0);
    for (int k = 0; k < 5; k++) begin
`ifdef CMP_SWAP_DESCEND_EN
      chk("sorted", 32'(ram[k]), 32'(5 - k));
`else
      chk("sorted", 32'(ram[k]), 32'(k + 1));
`endif
    end
    chk("sort_cnt", 32'(o_swap_cnt), 32'd10);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/cmp_swap_stage.md
Name: cmp_swap_stage

Overview:
- Datapath stage directly downstream of the inner-loop index generator (j counter) of the bubble-sort controller.
- On each start pulse carrying index j, reads mem[j] and mem[j+1] from a single-port synchronous RAM and compares them.
- Writes them back swapped if they are out of order, then pulses o_done.
- o_done feeds the j generator's enable, closing the i/j/compare handshake loop.

Parameters:
SIZE_ADDR, 8, width of index and RAM address
DATA_W, 16, width of RAM data words
CNT_W, 16, width of swap counter

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
i_start  input  1  one-cycle pulse from j generator (registered o_en of J stage); j valid this cycle
i_value_j  input  SIZE_ADDR  index j; compare pair (j, j+1)
i_clr_cnt  input  1  synchronous clear of o_swap_cnt
o_mem_addr  output  SIZE_ADDR  RAM address
o_mem_re  output  1  RAM read enable
o_mem_we  output  1  RAM write enable
o_mem_wdata  output  DATA_W  RAM write data
i_mem_rdata  input  DATA_W  RAM read data, valid one cycle after o_mem_re
o_busy  output  1  high in any state except IDLE
o_done  output  1  one-cycle pulse, pair processed
o_swapped  output  1  valid with o_done: 1 if pair was exchanged
o_swap_cnt  output  CNT_W  saturating count of swaps performed

Behaviour:
- Reset is asynchronous on rst_n low. Resulting values: state IDLE; all outputs 0; internal a/b/j registers 0; o_swap_cnt 0.
- Reset asserted mid-operation aborts immediately. No write is issued after reset assertion, and no o_done is produced for the aborted pair.
- FSM states: IDLE, RD0, RD1, CMP, WR0, WR1, DONE.
- IDLE: i_start=1 latches i_value_j into j_r, next state RD0. i_start in any other state is ignored (no queuing).
- RD0: o_mem_addr=j_r, o_mem_re=1. Next RD1.
- RD1: o_mem_addr=j_r+1, o_mem_re=1. Capture a=i_mem_rdata (mem[j]). Next CMP.
- CMP: capture b=i_mem_rdata (mem[j+1]). The compare is combinational on a and the incoming b.
  - swap = (a > b), unsigned.
  - swap=1: next WR0, and a/b are registered for the writes.
  - swap=0: next DONE.
  - Equal values never swap, so the sort is stable.
- WR0: o_mem_addr=j_r, o_mem_we=1, o_mem_wdata=b. Next WR1.
- WR1: o_mem_addr=j_r+1, o_mem_we=1, o_mem_wdata=a. Next DONE.
- DONE: o_done=1 and o_swapped=swap flag. o_swap_cnt increments on this cycle if swapped. Next IDLE.
- Latency, counting i_start sampled at edge T:
  - no swap: o_done high in the cycle after edge T+3 (4 cycles start-to-done);
  - swap: o_done high in the cycle after edge T+5 (6 cycles).
- o_mem_re and o_mem_we are never high together. In states where an enable is inactive, o_mem_addr/o_mem_wdata are 0.
- j_r+1 is computed modulo 2^SIZE_ADDR: j=2^SIZE_ADDR-1 wraps to address 0. Keeping j <= num_elems-2 is the upstream's contract; this block does no range check.
- o_swap_cnt saturates at 2^CNT_W-1.
- i_clr_cnt has priority over an increment in the same cycle.
- o_swapped is 0 outside DONE.

Optional Feature:
- Macro: CMP_SWAP_DESCEND_EN.
- Defined: swap = (a < b), producing a descending sort.
- Undefined: swap = (a > b), producing an ascending sort.
- Compare is unsigned in both builds. Timing and interface are identical in both builds.

Test Plan:
- mem[3]=9, mem[4]=2; pulse i_start with j=3 -> reads at addr 3 then 4; writes 2 to addr 3 and 9 to addr 4; o_done with o_swapped=1 six cycles after start; o_swap_cnt=1.
- mem[0]=1, mem[1]=7; start j=0 -> no o_mem_we at any cycle; o_done with o_swapped=0 four cycles after start; counter unchanged.
- mem[5]=mem[6]=4; start j=5 -> no swap (stability); o_swapped=0.
- i_start pulsed again during RD1 -> ignored; exactly one o_done; then a new start is accepted from IDLE.
- rst_n dropped during WR0 -> o_mem_we=0 immediately; no write to addr j+1; no o_done; outputs 0; state IDLE.
- Full loop with the i/j generators, num_elems=5, RAM {5,4,3,2,1} -> final RAM {1,2,3,4,5}; o_swap_cnt=10. With CMP_SWAP_DESCEND_EN on input {1,2,3,4,5} -> {5,4,3,2,1}.
